// File: rtl/cond_issue_ctrl.sv
// cond_issue_ctrl: owns the NZCV status register and gates ID->EXE issue of
// conditional instructions while flag-setting producers are still in flight.
// Optional build macro: COND_FLAG_BYPASS_EN (evaluate against sr_in during the
// flag write cycle and release the stall one cycle earlier).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no flag-setting instruction in flight, cnt == 0
// WAIT  | flags pending, cnt counts down to the producer's sr_we cycle
module cond_issue_ctrl #(
  parameter int FLAG_LAT = 2,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       flush,
  input  logic       sr_we,
  input  logic [3:0] sr_in,
  output logic [3:0] sr_out,
  output logic       ex_valid,
  output logic       ex_cond_pass,
  output logic       ex_s_en,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       sr;
  logic [3:0]       flags;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             pass;
  logic             needs_flags;
  logic             stall;
  logic             issue;
  logic             load;

  // Flags seen by the condition evaluator
  always_comb begin
`ifdef COND_FLAG_BYPASS_EN
    flags = sr_we ? sr_in : sr;
`else
    flags = sr;
`endif
  end

  assign flag_n = flags[3];
  assign flag_z = flags[2];
  assign flag_c = flags[1];
  assign flag_v = flags[0];

  // ARM condition field decode
  always_comb begin
    pass = 1'b0;
    case (id_cond)
      4'b0000: pass = flag_z;
      4'b0001: pass = ~flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = ~flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = ~flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = ~flag_v;
      4'b1000: pass = flag_c & ~flag_z;
      4'b1001: pass = ~flag_c | flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = ~flag_z & (flag_n == flag_v);
      4'b1101: pass = flag_z | (flag_n != flag_v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // AL and NV never look at the flags, so they never wait on them
  assign needs_flags = (id_cond[3:1] != 3'b111);

  // Issue gating; the bypass build lets the dependent slip into the write cycle
  always_comb begin
`ifdef COND_FLAG_BYPASS_EN
    stall = id_valid & needs_flags & (cnt != '0) & ~flush
          & ~((cnt == CNT_W'(1)) & sr_we);
`else
    stall = id_valid & needs_flags & (cnt != '0) & ~flush;
`endif
  end

  assign id_ready = ~stall;
  assign issue    = id_valid & ~stall & ~flush;
  // A failing S instruction never writes flags, so it must not start a wait
  assign load     = issue & id_s & pass;

  // Pending countdown and IDLE/WAIT sequencing; youngest producer reloads
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (load) begin
      cnt_nxt = CNT_W'(FLAG_LAT);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
    case (state)
      IDLE:    if (load) state_nxt = WAIT;
      WAIT:    if (!load && (cnt == CNT_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, flag register and EXE issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= 4'b0000;
      ex_valid     <= 1'b0;
      ex_cond_pass <= 1'b0;
      ex_s_en      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      if (sr_we) sr <= sr_in;
      ex_valid     <= issue;
      ex_cond_pass <= issue & pass;
      ex_s_en      <= load;
    end
  end

  assign sr_out = sr;
  assign busy   = (state == WAIT);

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Bench for cond_issue_ctrl: directed test-plan sequences with literal
// expectations, then randomized traffic checked every cycle against a
// timestamp-based model of flag readiness.
module tb_cond_issue_ctrl;

  localparam int FLAG_LAT = 2;
`ifdef COND_FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic       id_ready;
  logic [3:0] id_cond;
  logic       id_s;
  logic       flush;
  logic       sr_we;
  logic [3:0] sr_in;
  logic [3:0] sr_out;
  logic       ex_valid;
  logic       ex_cond_pass;
  logic       ex_s_en;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  cond_issue_ctrl #(.FLAG_LAT(FLAG_LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_cond(id_cond), .id_s(id_s), .flush(flush), .sr_we(sr_we),
    .sr_in(sr_in), .sr_out(sr_out), .ex_valid(ex_valid),
    .ex_cond_pass(ex_cond_pass), .ex_s_en(ex_s_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Condition table: odd codes invert the even code below them
  function automatic bit ev(input logic [3:0] c, input logic [3:0] f);
    bit base [8];
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = '{z, cy, n, v, cy & ~z, n == v, ~z & (n == v), 1'b1};
    return base[c[3:1]] ^ c[0];
  endfunction

  // Model state: flags are pending in every cycle up to and including pend_until
  int       cyc = 0;
  int       pend_until = -100;
  bit       armed = 1'b0;
  bit [3:0] m_sr = '0;
  bit       m_exv = 0, m_exp = 0, m_exs = 0;

  function automatic bit m_ready();
    bit pending, last, nf;
    pending = (cyc <= pend_until);
    last    = (cyc == pend_until);
    nf      = (id_cond != 4'b1110) && (id_cond != 4'b1111);
    return !(id_valid && nf && pending && !flush && !(BYP && last && sr_we));
  endfunction

  // Reference model advances on each clock edge
  always @(posedge clk) begin
    bit [3:0] f;
    bit       p, iss;
    if (rst) begin
      armed = 1'b1;
      m_sr = '0; m_exv = 0; m_exp = 0; m_exs = 0;
      pend_until = -100;
    end else begin
      f   = (BYP && sr_we) ? sr_in : m_sr;
      p   = ev(id_cond, f);
      iss = id_valid && m_ready() && !flush;
      m_exv = iss;
      m_exp = iss && p;
      m_exs = iss && p && id_s;
      if (iss && id_s && p) pend_until = cyc + FLAG_LAT;
      if (sr_we) m_sr = sr_in;
    end
    cyc++;
  end

  // Compare all outputs against the model every cycle, mid-period
  always @(negedge clk) begin
    if (armed) begin
      chk("m_id_ready", {3'b0, id_ready}, {3'b0, m_ready()});
      chk("m_sr_out", sr_out, m_sr);
      chk("m_ex_valid", {3'b0, ex_valid}, {3'b0, m_exv});
      chk("m_ex_cond_pass", {3'b0, ex_cond_pass}, {3'b0, m_exp});
      chk("m_ex_s_en", {3'b0, ex_s_en}, {3'b0, m_exs});
      chk("m_busy", {3'b0, busy}, {3'b0, cyc <= pend_until});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [3:0] c, input bit s, input bit fl,
                     input bit we, input logic [3:0] si);
    id_valid = v; id_cond = c; id_s = s; flush = fl; sr_we = we; sr_in = si;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;

    // Reset state and an AL issue
    rst = 1'b0;
    drv(1, 4'b1110, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("rst_sr_out", sr_out, 4'b0000);
    chk("rst_ex_valid", {3'b0, ex_valid}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("al_ready", {3'b0, id_ready}, 4'd1);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("al_ex_valid", {3'b0, ex_valid}, 4'd1);
    chk("al_pass", {3'b0, ex_cond_pass}, 4'd1);
    chk("al_s_en", {3'b0, ex_s_en}, 4'd0);
    chk("al_busy", {3'b0, busy}, 4'd0);

    // Z set: EQ passes, NE fails
    nxt(); drv(0, 4'b0000, 0, 0, 1, 4'b0100);
    nxt(); drv(1, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("z_sr_out", sr_out, 4'b0100);
    nxt(); drv(1, 4'b0001, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("eq_ex_valid", {3'b0, ex_valid}, 4'd1);
    chk("eq_pass", {3'b0, ex_cond_pass}, 4'd1);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("ne_ex_valid", {3'b0, ex_valid}, 4'd1);
    chk("ne_pass", {3'b0, ex_cond_pass}, 4'd0);

    // AL.S then GT held; flags written to 0000 in cycle 2
    nxt(); drv(1, 4'b1110, 1, 0, 0, 4'b0000);
    @(negedge clk);
    chk("c0_ready", {3'b0, id_ready}, 4'd1);
    nxt(); drv(1, 4'b1100, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("c1_ready", {3'b0, id_ready}, 4'd0);
    chk("c1_busy", {3'b0, busy}, 4'd1);
    nxt(); drv(1, 4'b1100, 0, 0, 1, 4'b0000);
    @(negedge clk);
`ifdef COND_FLAG_BYPASS_EN
    chk("c2_ready", {3'b0, id_ready}, 4'd1);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("c3_ex_valid", {3'b0, ex_valid}, 4'd1);
    chk("c3_pass", {3'b0, ex_cond_pass}, 4'd1);
`else
    chk("c2_ready", {3'b0, id_ready}, 4'd0);
    nxt(); drv(1, 4'b1100, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("c3_ready", {3'b0, id_ready}, 4'd1);
    chk("c3_busy", {3'b0, busy}, 4'd0);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("c4_ex_valid", {3'b0, ex_valid}, 4'd1);
    chk("c4_pass", {3'b0, ex_cond_pass}, 4'd1);
`endif

    // Failing S instruction (EQ with Z clear) does not start a wait
    nxt(); drv(1, 4'b0000, 1, 0, 0, 4'b0000);
    nxt(); drv(1, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("fs_s_en", {3'b0, ex_s_en}, 4'd0);
    chk("fs_pass", {3'b0, ex_cond_pass}, 4'd0);
    chk("fs_busy", {3'b0, busy}, 4'd0);
    chk("fs_next_ready", {3'b0, id_ready}, 4'd1);

    // Flush during WAIT squashes but leaves the countdown running
    nxt(); drv(1, 4'b1110, 1, 0, 0, 4'b0000);
    nxt(); drv(1, 4'b0000, 0, 1, 0, 4'b0000);
    @(negedge clk);
    chk("fl_busy", {3'b0, busy}, 4'd1);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("fl_ex_valid", {3'b0, ex_valid}, 4'd0);
    chk("fl_busy_cnt1", {3'b0, busy}, 4'd1);
    nxt();
    @(negedge clk);
    chk("fl_busy_done", {3'b0, busy}, 4'd0);

    // Reset with cnt==2 drops the wait; a later sr_we still lands
    nxt(); drv(1, 4'b1110, 1, 0, 0, 4'b0000);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000); rst = 1'b1;
    @(negedge clk);
    chk("rw_busy_before", {3'b0, busy}, 4'd1);
    nxt(); rst = 1'b0; drv(0, 4'b0000, 0, 0, 1, 4'b1010);
    @(negedge clk);
    chk("rw_busy", {3'b0, busy}, 4'd0);
    chk("rw_ex_valid", {3'b0, ex_valid}, 4'd0);
    chk("rw_sr_out", sr_out, 4'b0000);
    nxt(); drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("rw_sr_written", sr_out, 4'b1010);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 4000; i++) begin
      nxt();
      rst      = ($urandom_range(0, 99) == 0);
      id_valid = ($urandom_range(0, 9) < 7);
      id_cond  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      id_s     = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 9) == 0);
      sr_we    = ($urandom_range(0, 4) == 0);
      sr_in    = 4'($urandom_range(0, 15));
    end
    nxt();
    drv(0, 4'b0000, 0, 0, 0, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
